// File: rtl/matvec_sequencer_if.sv
// Signal bundle between matvec_sequencer and its job source, vector buffer,
// multiplier and result sink. The sequencer uses the master modport.
interface matvec_sequencer_if #(
  parameter int MAX_ROWS   = 64,
  parameter int MAX_COLS   = 64,
  parameter int BANDWIDTH  = 16,
  parameter int DATA_WIDTH = 16
);
  localparam int RW = $clog2(MAX_ROWS);
  localparam int CW = $clog2(MAX_COLS);

  // Handshake: a job transfers on a rising edge with job_valid && job_ready;
  // vec_rd_data answers vec_rd_en one cycle later; out_valid, done and err
  // are strobes with no ready, so the sink must take every one of them.
  logic                            job_valid;
  logic                            job_ready;
  logic [RW:0]                     job_rows;
  logic [CW:0]                     job_cols;

  logic                            vec_rd_en;
  logic [CW-1:0]                   vec_rd_addr;
  logic [DATA_WIDTH*BANDWIDTH-1:0] vec_rd_data;

  logic                            mv_start;
  logic [RW:0]                     mv_num_rows;
  logic [CW:0]                     mv_num_cols;
  logic                            mv_vector_write_enable;
  logic [CW-1:0]                   mv_vector_base_addr;
  logic [DATA_WIDTH*BANDWIDTH-1:0] mv_vector_in;
  logic [2*DATA_WIDTH-1:0]         mv_result_out;
  logic                            mv_result_valid;
  logic                            mv_busy;

  logic                            out_valid;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [RW-1:0]                   out_row;
  logic                            done;
  logic                            err;
  logic [1:0]                      err_code;

  logic [2:0]                      fsm_state;

  modport master (
    input  job_valid, job_rows, job_cols, vec_rd_data,
           mv_result_out, mv_result_valid, mv_busy,
    output job_ready, vec_rd_en, vec_rd_addr,
           mv_start, mv_num_rows, mv_num_cols, mv_vector_write_enable,
           mv_vector_base_addr, mv_vector_in,
           out_valid, out_data, out_row, done, err, err_code, fsm_state
  );

  modport slave (
    output job_valid, job_rows, job_cols, vec_rd_data,
           mv_result_out, mv_result_valid, mv_busy,
    input  job_ready, vec_rd_en, vec_rd_addr,
           mv_start, mv_num_rows, mv_num_cols, mv_vector_write_enable,
           mv_vector_base_addr, mv_vector_in,
           out_valid, out_data, out_row, done, err, err_code, fsm_state
  );
endinterface

// File: rtl/matvec_sequencer.sv
// Job-level controller for matvec_mult: streams the vector in chunks, starts
// the multiplier, and requantizes each Q20.12 row result to saturated Q4.12.
module matvec_sequencer #(
  parameter int MAX_ROWS   = 64,
  parameter int MAX_COLS   = 64,
  parameter int BANDWIDTH  = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 1024
) (
  input logic clk,
  input logic rst_n,
  matvec_sequencer_if.master bus
);
  localparam int RW = $clog2(MAX_ROWS);
  localparam int CW = $clog2(MAX_COLS);
  localparam int DW = DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [RW:0]   ROWS_LIMIT = (RW + 1)'(MAX_ROWS);
  localparam logic [CW:0]   COLS_LIMIT = (CW + 1)'(MAX_COLS);
  localparam logic [CW+1:0] CHUNK_STEP = (CW + 2)'(BANDWIDTH);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_FETCH   = 3'd2,
    S_WRITE   = 3'd3,
    S_COLLECT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [RW:0]   rows_q;
  logic [CW:0]   cols_q;
  logic [CW:0]   base_q;
  logic [RW:0]   row_q;
  logic [TW-1:0] tmo_q;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic [RW-1:0] out_row_q;
  logic          err_q;
  logic [1:0]    err_code_q;

  logic                   accept;
  logic                   bad_dims;
  logic                   capture;
  logic                   last_row;
  logic                   more_chunks;
  logic                   timeout_hit;
  logic [CW+1:0]          next_base;
  logic [DW:0]            top_bits;
  logic [DW-1:0]          sat_data;
  logic [DW*BANDWIDTH-1:0] masked_chunk;

  assign bus.job_ready = (state == S_IDLE) && !bus.mv_busy;
  assign accept        = bus.job_valid && bus.job_ready;
  assign bad_dims      = (bus.job_rows == '0) || (bus.job_cols == '0) ||
                         (bus.job_rows > ROWS_LIMIT) || (bus.job_cols > COLS_LIMIT);

  // Results may arrive while the vector is still streaming, so capture spans
  // every active state, not just COLLECT.
  assign capture     = bus.mv_result_valid &&
                       (state inside {S_START, S_FETCH, S_WRITE, S_COLLECT});
  assign last_row    = capture && (row_q == rows_q - 1'b1);
  assign next_base   = {1'b0, base_q} + CHUNK_STEP;
  assign more_chunks = next_base < {1'b0, cols_q};
  assign timeout_hit = (state == S_COLLECT) && !bus.mv_result_valid && (tmo_q == TMO_LAST);

  // Saturation: the value fits in DW signed bits only when the top DW+1 bits
  // are all equal (pure sign extension).
  assign top_bits = bus.mv_result_out[2*DW-1:DW-1];

  always_comb begin
    sat_data = bus.mv_result_out[DW-1:0];
    if (!top_bits[DW] && (|top_bits)) begin
      sat_data = {1'b0, {(DW - 1){1'b1}}};
    end else if (top_bits[DW] && !(&top_bits)) begin
      sat_data = {1'b1, {(DW - 1){1'b0}}};
    end
  end

  always_comb begin
    masked_chunk = '0;
    for (int i = 0; i < BANDWIDTH; i++) begin
      if (int'(base_q) + i < int'(cols_q)) begin
        masked_chunk[i*DW +: DW] = bus.vec_rd_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (accept && !bad_dims) state_nx = S_START;
      S_START:   state_nx = S_FETCH;
      S_FETCH:   state_nx = S_WRITE;
      S_WRITE:   state_nx = more_chunks ? S_FETCH : S_COLLECT;
      S_COLLECT: if (timeout_hit) state_nx = S_IDLE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
    if (last_row) begin
      state_nx = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q      <= '0;
      cols_q      <= '0;
      base_q      <= '0;
      row_q       <= '0;
      tmo_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;

      if (accept) begin
        rows_q <= bus.job_rows;
        cols_q <= bus.job_cols;
        base_q <= '0;
        row_q  <= '0;
        if (bad_dims) begin
          err_q      <= 1'b1;
          err_code_q <= 2'b01;
        end else begin
          err_code_q <= 2'b00;
        end
      end

      if ((state == S_WRITE) && more_chunks) begin
        base_q <= next_base[CW:0];
      end

      if (capture || ((state == S_WRITE) && !more_chunks)) begin
        tmo_q <= '0;
      end else if (state == S_COLLECT) begin
        tmo_q <= tmo_q + 1'b1;
      end

      if (timeout_hit) begin
        err_q      <= 1'b1;
        err_code_q <= 2'b10;
      end

      if (capture) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sat_data;
        out_row_q   <= row_q[RW-1:0];
        row_q       <= row_q + 1'b1;
      end
    end
  end

  assign bus.mv_start               = (state == S_START);
  assign bus.vec_rd_en              = (state == S_FETCH);
  assign bus.vec_rd_addr            = (state == S_FETCH) ? base_q[CW-1:0] : '0;
  assign bus.mv_vector_write_enable = (state == S_WRITE);
  assign bus.mv_vector_base_addr    = (state == S_WRITE) ? base_q[CW-1:0] : '0;
  assign bus.mv_vector_in           = (state == S_WRITE) ? masked_chunk : '0;
  assign bus.mv_num_rows            = rows_q;
  assign bus.mv_num_cols            = cols_q;
  assign bus.out_valid              = out_valid_q;
  assign bus.out_data               = out_data_q;
  assign bus.out_row                = out_row_q;
  assign bus.done                   = (state == S_DONE);
  assign bus.err                    = err_q;
  assign bus.err_code               = err_code_q;
  assign bus.fsm_state              = state;
endmodule

// File: doc/matvec_sequencer.md
# matvec_sequencer

Job-level controller for `matvec_mult`.
- Accepts a job (row/column count), streams the input vector from a banked vector buffer into the multiplier in BANDWIDTH-wide chunks, and pulses start.
- Collects one Q20.12 result per row, requantizes each to saturated Q4.12, and emits it with its row index.
- Sits between the LSTM gate scheduler and `matvec_mult`/`matrix_loader`, replacing bench-driven sequencing.

## Interface
Parameters:
- MAX_ROWS, 64, max rows supported by attached matvec_mult
- MAX_COLS, 64, max columns
- BANDWIDTH, 16, vector lanes per chunk
- DATA_WIDTH, 16, Q4.12 element width
- TIMEOUT, 1024, max cycles between results in COLLECT

Ports (RW = $clog2(MAX_ROWS), CW = $clog2(MAX_COLS)):
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- job_valid  in  1  job request
- job_ready  out  1  high only in IDLE with mv_busy low
- job_rows  in  RW+1  row count
- job_cols  in  CW+1  column count
- vec_rd_en  out  1  vector buffer read strobe
- vec_rd_addr  out  CW  element index of chunk base
- vec_rd_data  in  DATA_WIDTH*BANDWIDTH  read data, valid 1 cycle after vec_rd_en
- mv_start  out  1  start pulse to matvec_mult
- mv_num_rows  out  RW+1  held job rows
- mv_num_cols  out  CW+1  held job cols
- mv_vector_write_enable  out  1  chunk write strobe
- mv_vector_base_addr  out  CW  chunk base index
- mv_vector_in  out  DATA_WIDTH*BANDWIDTH  chunk data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- mv_result_out  in  2*DATA_WIDTH  Q20.12 row result
- mv_result_valid  in  1  result strobe
- mv_busy  in  1  multiplier busy
- out_valid  out  1  requantized result strobe
- out_data  out  DATA_WIDTH  saturated Q4.12 result
- out_row  out  RW  row index of out_data
- done  out  1  job-complete pulse
- err  out  1  error pulse
- err_code  out  2  01 = bad dimensions, 10 = timeout; held until next job accept

## Operation
- States: IDLE, START, FETCH, WRITE, COLLECT, DONE.
- IDLE:
  - Job accepted on posedge with job_valid && job_ready; rows/cols latched onto mv_num_rows/mv_num_cols.
  - If rows==0, cols==0, rows>MAX_ROWS or cols>MAX_COLS: err=1, err_code=01 next cycle, stay IDLE, no mv_start.
- START: mv_start=1 for one cycle; chunk index k=0, row counter r=0.
- FETCH: vec_rd_en=1, vec_rd_addr=k*BANDWIDTH.
- WRITE:
  - mv_vector_write_enable=1, mv_vector_base_addr=k*BANDWIDTH, mv_vector_in=vec_rd_data.
  - Lanes whose index k*BANDWIDTH+i >= cols are forced to 0.
  - Chunk count = ceil(cols/BANDWIDTH). More chunks → FETCH with k+1; else → COLLECT.
- Result capture is active in START, FETCH, WRITE and COLLECT:
  - Each mv_result_valid registers out_data = sat16(mv_result_out), out_row = r, out_valid = 1, then r++.
  - sat16: clamp the signed 32-bit value to [-32768, 32767], then take the low 16 bits. Fractional bits are unchanged (12→12).
- No backpressure on out_valid; the consumer must accept every cycle.
- When the result with r == rows-1 is captured → DONE.
- DONE: done=1 for one cycle, → IDLE.
- Timeout:
  - Counter cleared on entering COLLECT and on each mv_result_valid.
  - Reaching TIMEOUT in COLLECT: err=1, err_code=10, → IDLE; remaining results are discarded.
- mv_result_valid in IDLE or DONE is ignored.

## Timing
- Reset values: every output 0, except job_ready, which is combinational (1 when IDLE and !mv_busy). State IDLE, err_code 00.
- Reset asserted mid-job: immediate return to IDLE, all strobes drop asynchronously, no done/err.
- Job accepted at edge T:
  - mv_start high in cycle T+1.
  - Chunk k: FETCH in cycle T+2+2k, WRITE in cycle T+3+2k.
- Result strobe at edge E → out_valid high in the cycle after E.
- For the last row, done is high in the same cycle as out_valid.
- job_ready is low from T+1 until the cycle after DONE or err.
- err and done are single-cycle pulses and never coincide.

## Test plan
- 4x4 instance (BANDWIDTH=4), loader rows alternating all-ones / zero, vector [1024]*4 → out_data 4096, 0, 4096, 0 with out_row 0..3; done with row 3; mv_start at T+1, single WRITE at T+3.
- Same 4x4 job with vector [4096, 8192, 12288, 16384] (raw 40960) → out_data 32767, 0, 32767, 0.
- 64x64, vector all -4096, half-ones rows (raw -131072) → 64 outputs of -32768; 4 WRITE strobes at base addresses 0, 16, 32, 48, two cycles apart.
- cols=20 on 32x32 → 2 chunks; second chunk lanes 4..15 zero on mv_vector_in; cols=0 → err, err_code=01 at T+1, no mv_start, job_ready back high.
- Stub holding mv_result_valid low → err, err_code=10 exactly TIMEOUT cycles after entering COLLECT; a following valid job completes normally.
- rst_n pulsed low during WRITE of chunk 2 → outputs 0 immediately, IDLE; a fresh job after release produces correct results.
